// File: rtl/exc_flush_ctrl.sv
// rtl/exc_flush_ctrl.sv - exception/interrupt commit, pipeline flush and redirect sequencer
module exc_flush_ctrl #(
   parameter int DRAIN_CYCLES = 2,
   parameter int PC_W         = 32
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            wb_valid,
   input  logic [PC_W-1:0] wb_pc,
   input  logic [4:0]      wb_exc,
   input  logic            wb_ertn,
   input  logic            has_int,
   input  logic [PC_W-1:0] ex_entry,
   input  logic [PC_W-1:0] ertn_entry,
   output logic            csr_wb_ex,
   output logic            csr_ertn_flush,
   output logic [5:0]      csr_ecode,
   output logic [8:0]      csr_esubcode,
   output logic [PC_W-1:0] csr_wb_pc,
   output logic            flush_o,
   output logic            wb_stall,
   output logic            redirect_valid,
   output logic [PC_W-1:0] redirect_pc,
   input  logic            redirect_ready
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_COMMIT   = 2'd1,
      S_REDIRECT = 2'd2,
      S_DRAIN    = 2'd3
   } state_e;

   localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

   state_e          state_q, state_d;
   logic            ertn_q, ertn_d;
   logic [5:0]      ecode_q, ecode_d;
   logic [8:0]      esub_q, esub_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] target_q, target_d;
   logic [3:0]      cnt_q, cnt_d;

   // wb_exc bit order: {adef, sys, brk, ine, ale}; an interrupt outranks all of them
   logic exc_any;
   assign exc_any = has_int | (|wb_exc);

   // State and latched event context; reset clears everything so no stale commit survives
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         ertn_q   <= 1'b0;
         ecode_q  <= '0;
         esub_q   <= '0;
         pc_q     <= '0;
         target_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         ertn_q   <= ertn_d;
         ecode_q  <= ecode_d;
         esub_q   <= esub_d;
         pc_q     <= pc_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
      end
   end

   // Next-state, event arbitration and state-decoded outputs
   always_comb begin
      state_d        = state_q;
      ertn_d         = ertn_q;
      ecode_d        = ecode_q;
      esub_d         = esub_q;
      pc_d           = pc_q;
      target_d       = target_q;
      cnt_d          = cnt_q;
      csr_wb_ex      = 1'b0;
      csr_ertn_flush = 1'b0;
      csr_ecode      = '0;
      csr_esubcode   = '0;
      csr_wb_pc      = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      flush_o        = (state_q != S_IDLE);
      wb_stall       = (state_q != S_IDLE);

      unique case (state_q)
         S_IDLE: begin
            if (wb_valid && (exc_any || wb_ertn)) begin
               ertn_d  = !exc_any;
               esub_d  = '0;
               pc_d    = wb_pc;
               if (has_int)        ecode_d = 6'h00;
               else if (wb_exc[4]) ecode_d = 6'h08;
               else if (wb_exc[3]) ecode_d = 6'h0B;
               else if (wb_exc[2]) ecode_d = 6'h0C;
               else if (wb_exc[1]) ecode_d = 6'h0D;
               else if (wb_exc[0]) ecode_d = 6'h09;
               else                ecode_d = 6'h00;
               state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            if (ertn_q) begin
               csr_ertn_flush = 1'b1;
               target_d       = ertn_entry;
            end else begin
               csr_wb_ex    = 1'b1;
               csr_ecode    = ecode_q;
               csr_esubcode = esub_q;
               csr_wb_pc    = pc_q;
               target_d     = ex_entry;
            end
            state_d = S_REDIRECT;
         end
         S_REDIRECT: begin
            redirect_valid = 1'b1;
            redirect_pc    = target_q;
            if (redirect_ready) begin
               cnt_d   = DRAIN_LOAD;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (cnt_q == 4'd0) state_d = S_IDLE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule
